// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - X-step counter sequencer for rectangular pattern scans
//
// Walks a rectangular region line by line. It seeds and steps an external
// registered X counter, then presents each (x, y) coordinate downstream over a
// valid/ready handshake.
//
// Optional feature macro: PATTERN_SCAN_ABORT_EN (adds the abort input).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               scan request, sampled in IDLE only
//   x_start, x_end      first / last (inclusive) X of each line
//   y_lines             number of lines to scan
//   step_mode           X step per pixel: 00=0, 01=1, 10=4, 11=8
//   cnt_out             registered counter result (candidate X)
//   pix_ready           downstream accepts the current pixel
//   cnt_enb, Xmode,     counter control; decoded from state and the accept
//   LoadVal             condition, zero whenever the counter is not used
//   pix_x, pix_y        current pixel coordinate
//   pix_valid           pixel coordinate valid
//   busy                scan in progress
//   done                one-cycle completion pulse
//   abort               (PATTERN_SCAN_ABORT_EN only) return to IDLE at once
module pattern_scan_ctrl #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x_start,
  input  logic [W-1:0] x_end,
  input  logic [W-1:0] y_lines,
  input  logic [1:0]   step_mode,
  input  logic [W-1:0] cnt_out,
  input  logic         pix_ready,
  output logic         cnt_enb,
  output logic [1:0]   Xmode,
  output logic [W-1:0] LoadVal,
  output logic [W-1:0] pix_x,
  output logic [W-1:0] pix_y,
  output logic         pix_valid,
  output logic         busy,
  output logic         done
`ifdef PATTERN_SCAN_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_CAPT,
    S_EMIT,
    S_LINE,
    S_DONE
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] x_start_q;
  logic [W-1:0] x_end_q;
  logic [W-1:0] y_lines_q;
  logic [1:0]   step_q;
  logic         first_q;     // next captured X is the first pixel of the line
  logic         abort_hit;
  logic         accept;
  logic         line_end;
  logic [W-1:0] y_next;

`ifdef PATTERN_SCAN_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = (state == S_EMIT) && pix_valid && pix_ready;

  // A candidate below the previous X can only come from the counter wrapping
  // past 2^W, so it also ends the line.
  assign line_end = (cnt_out > x_end_q) || (!first_q && (cnt_out < pix_x));

  assign y_next = pix_y + 1'b1;

  always_comb begin
    state_nx = state;
    cnt_enb  = 1'b0;
    Xmode    = 2'b00;
    LoadVal  = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (y_lines == '0) ? S_DONE : S_SEED;
        end
      end
      S_SEED: begin
        // Step 0 makes the counter return x_start unchanged.
        cnt_enb  = 1'b1;
        LoadVal  = x_start_q;
        state_nx = S_CAPT;
      end
      S_CAPT: begin
        state_nx = line_end ? S_LINE : S_EMIT;
      end
      S_EMIT: begin
        if (accept) begin
          if (step_q == 2'b00) begin
            state_nx = S_LINE;
          end else begin
            cnt_enb  = 1'b1;
            Xmode    = step_q;
            LoadVal  = pix_x;
            state_nx = S_CAPT;
          end
        end
      end
      S_LINE: begin
        state_nx = (y_next == y_lines_q) ? S_DONE : S_SEED;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (abort_hit) begin
      state_nx = S_IDLE;
      cnt_enb  = 1'b0;
      Xmode    = 2'b00;
      LoadVal  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x_start_q <= '0;
      x_end_q   <= '0;
      y_lines_q <= '0;
      step_q    <= 2'b00;
      first_q   <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != S_IDLE);
      pix_valid <= (state_nx == S_EMIT);
      // The pulse follows the DONE state by one cycle, once the scan is over.
      done      <= (state == S_DONE) && !abort_hit;
      if (abort_hit) begin
        first_q <= 1'b0;
        pix_x   <= '0;
        pix_y   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              x_start_q <= x_start;
              x_end_q   <= x_end;
              y_lines_q <= y_lines;
              step_q    <= step_mode;
              pix_y     <= '0;
            end
          end
          S_SEED: first_q <= 1'b1;
          S_CAPT: begin
            if (!line_end) begin
              pix_x <= cnt_out;
            end
          end
          S_EMIT: begin
            if (accept) begin
              first_q <= 1'b0;
            end
          end
          S_LINE: pix_y <= y_next;
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - table-driven self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] x_start = '0;
  logic [11:0] x_end = '0;
  logic [11:0] y_lines = '0;
  logic [1:0]  step_mode = 2'b00;
  logic [11:0] cnt_out;
  logic        pix_ready = 1'b0;
  logic        cnt_enb;
  logic [1:0]  Xmode;
  logic [11:0] LoadVal;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_valid;
  logic        busy;
  logic        done;
  logic        abort = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_start   (x_start),
    .x_end     (x_end),
    .y_lines   (y_lines),
    .step_mode (step_mode),
    .cnt_out   (cnt_out),
    .pix_ready (pix_ready),
    .cnt_enb   (cnt_enb),
    .Xmode     (Xmode),
    .LoadVal   (LoadVal),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .busy      (busy),
    .done      (done)
`ifdef PATTERN_SCAN_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Behavioural model of the registered X-step counter.
  function automatic logic [11:0] step_of(input logic [1:0] m);
    case (m)
      2'b01:   return 12'd1;
      2'b10:   return 12'd4;
      2'b11:   return 12'd8;
      default: return 12'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_out <= '0;
    else if (cnt_enb) cnt_out <= LoadVal + step_of(Xmode);
    else              cnt_out <= '0;
  end

  typedef struct {
    logic [11:0] xs;
    logic [11:0] xe;
    logic [11:0] yl;
    logic [1:0]  sm;
    int          stall_idx;  // accept index to stall on (-1 = none)
    int          stall_len;
    int          restart_k;  // cycle to pulse a spurious start (0 = none)
    int          n;          // expected pixel count
    int          done_k;     // expected cycle of the done pulse after start
    logic [11:0] ex [8];
    logic [11:0] ey [8];
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int i, input int xs, input int xe, input int yl, input int sm,
                         input int sidx, input int slen, input int rk, input int n, input int dk);
    vecs[i].xs = xs[11:0];
    vecs[i].xe = xe[11:0];
    vecs[i].yl = yl[11:0];
    vecs[i].sm = sm[1:0];
    vecs[i].stall_idx = sidx;
    vecs[i].stall_len = slen;
    vecs[i].restart_k = rk;
    vecs[i].n = n;
    vecs[i].done_k = dk;
    for (int j = 0; j < 8; j++) begin
      vecs[i].ex[j] = 12'd0;
      vecs[i].ey[j] = 12'd0;
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [11:0] gx [16];
    logic [11:0] gy [16];
    int          n_acc = 0;
    int          stall_cnt = 0;
    int          done_cnt = 0;
    int          done_at = 0;
    int          first_v = 0;
    int          busy_at_done = 0;
    logic        pv_prev = 1'b0;
    logic        acc_prev = 1'b0;
    logic        acc;
    logic [11:0] px_prev = '0;
    logic [11:0] py_prev = '0;
    v = vecs[idx];
    for (int j = 0; j < 16; j++) begin
      gx[j] = 12'hfff;
      gy[j] = 12'hfff;
    end
    @(negedge clk);
    x_start = v.xs; x_end = v.xe; y_lines = v.yl; step_mode = v.sm;
    start = 1'b1; pix_ready = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == v.restart_k) begin
        start = 1'b1; x_start = 12'd0; x_end = 12'd4000; y_lines = 12'd5; step_mode = 2'b01;
      end else begin
        start = 1'b0;
      end
      if (k == 1) chk($sformatf("v%0d busy_after_start", idx), int'(busy), 1);
      if (pv_prev && !acc_prev) begin
        chk($sformatf("v%0d hold_valid k%0d", idx, k), int'(pix_valid), 1);
        chk($sformatf("v%0d hold_x k%0d", idx, k), int'(pix_x), int'(px_prev));
        chk($sformatf("v%0d hold_y k%0d", idx, k), int'(pix_y), int'(py_prev));
      end
      if (pix_valid && first_v == 0) first_v = k;
      if (pix_valid && n_acc == v.stall_idx && stall_cnt < v.stall_len) begin
        pix_ready = 1'b0;
        stall_cnt++;
      end else begin
        pix_ready = 1'b1;
      end
      acc = pix_valid && pix_ready;
      if (acc && n_acc < 16) begin
        gx[n_acc] = pix_x;
        gy[n_acc] = pix_y;
      end
      if (acc) n_acc++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          busy_at_done = int'(busy);
        end
      end
      pv_prev = pix_valid; acc_prev = acc; px_prev = pix_x; py_prev = pix_y;
      if (done_at != 0 && k >= done_at + 3) break;
    end
    start = 1'b0;
    if (done_at == 0) chk($sformatf("v%0d done_timeout", idx), 0, 1);
    chk($sformatf("v%0d pixel_count", idx), n_acc, v.n);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("v%0d px%0d_x", idx, i), int'(gx[i]), int'(v.ex[i]));
      chk($sformatf("v%0d px%0d_y", idx, i), int'(gy[i]), int'(v.ey[i]));
    end
    chk($sformatf("v%0d done_pulses", idx), done_cnt, 1);
    chk($sformatf("v%0d done_cycle", idx), done_at, v.done_k);
    chk($sformatf("v%0d first_valid_cycle", idx), first_v, (v.n > 0) ? 3 : 0);
    chk($sformatf("v%0d busy_at_done", idx), busy_at_done, 0);
    chk($sformatf("v%0d busy_end", idx), int'(busy), 0);
    chk($sformatf("v%0d valid_end", idx), int'(pix_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    // idx, xs, xe, yl, sm, stall_idx, stall_len, restart_k, n, done_k
    set_cfg(0, 10, 20, 2, 2, -1, 0, 0, 6, 20);
    vecs[0].ex = '{12'd10, 12'd14, 12'd18, 12'd10, 12'd14, 12'd18, 12'd0, 12'd0};
    vecs[0].ey = '{12'd0, 12'd0, 12'd0, 12'd1, 12'd1, 12'd1, 12'd0, 12'd0};
    set_cfg(1, 10, 20, 2, 2, 1, 5, 0, 6, 25);
    vecs[1].ex = '{12'd10, 12'd14, 12'd18, 12'd10, 12'd14, 12'd18, 12'd0, 12'd0};
    vecs[1].ey = '{12'd0, 12'd0, 12'd0, 12'd1, 12'd1, 12'd1, 12'd0, 12'd0};
    set_cfg(2, 4090, 4095, 1, 3, -1, 0, 0, 1, 7);
    vecs[2].ex[0] = 12'd4090;
    set_cfg(3, 7, 20, 3, 0, -1, 0, 0, 3, 14);
    vecs[3].ex = '{12'd7, 12'd7, 12'd7, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    vecs[3].ey = '{12'd0, 12'd1, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    set_cfg(4, 10, 20, 0, 2, -1, 0, 0, 0, 2);
    set_cfg(5, 30, 20, 2, 1, -1, 0, 0, 0, 8);
    set_cfg(6, 100, 102, 1, 1, -1, 0, 4, 3, 11);
    vecs[6].ex = '{12'd100, 12'd101, 12'd102, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    set_cfg(7, 50, 50, 1, 2, -1, 0, 0, 1, 7);
    vecs[7].ex[0] = 12'd50;

    repeat (3) @(negedge clk);
    chk("reset_cnt_enb", int'(cnt_enb), 0);
    chk("reset_xmode", int'(Xmode), 0);
    chk("reset_loadval", int'(LoadVal), 0);
    chk("reset_pix_x", int'(pix_x), 0);
    chk("reset_pix_y", int'(pix_y), 0);
    chk("reset_valid", int'(pix_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset during the second line, then a fresh scan must start at y=0.
    @(negedge clk);
    x_start = 12'd10; x_end = 12'd20; y_lines = 12'd2; step_mode = 2'b10;
    start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (pix_valid && pix_y == 12'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reset_reached_line1", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", int'(pix_valid), 0);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_pix_x", int'(pix_x), 0);
    chk("mid_reset_pix_y", int'(pix_y), 0);
    chk("mid_reset_cnt_enb", int'(cnt_enb), 0);
    chk("mid_reset_loadval", int'(LoadVal), 0);
    @(negedge clk);
    chk("mid_reset_no_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_done", int'(done), 0);
    run_vec(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencer for the Patterns X-step counter. Walks a rectangular pattern region line by line and drives the counter's `cnt_enb`, `Xmode` and `LoadVal` inputs to generate successive X coordinates. It reads back the registered counter result and presents each (x, y) pixel coordinate to the downstream pattern writer over a valid/ready handshake. It sits between the pattern configuration registers and the counter instance.

## Interface
- `W`, default 12: coordinate width; must match the counter width.
- `clk` input 1: master clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a scan. Sampled only in IDLE.
- `x_start` input W: first X of each line. Latched on an accepted `start`.
- `x_end` input W: last allowed X, inclusive. Latched on an accepted `start`.
- `y_lines` input W: number of lines. Latched on an accepted `start`.
- `step_mode` input 2: X step per pixel. 00=0, 01=1, 10=4, 11=8. Latched on an accepted `start`.
- `cnt_out` input W: registered output of the counter.
- `pix_ready` input 1: downstream accepts a pixel.
- `cnt_enb` output 1: counter enable.
- `Xmode` output 2: counter step select.
- `LoadVal` output W: counter base value.
- `pix_x`, `pix_y` output W: current pixel coordinate.
- `pix_valid` output 1: pixel coordinate valid.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when the scan completes.

## Operation
- FSM states: IDLE, SEED, CAPT, EMIT, LINE, DONE.
- IDLE: `start`=1 latches all config, clears `pix_y` to 0, and moves to SEED. If `y_lines`==0, it moves to DONE instead.
- SEED: drives `cnt_enb`=1, `Xmode`=00, `LoadVal`=`x_start`, then moves to CAPT.
- CAPT: `cnt_out` now holds the candidate X.
  - End of line if `cnt_out` > `x_end`.
  - End of line if this is not the first pixel of the line and `cnt_out` < `pix_x` (12-bit wrap).
  - At end of line, move to LINE.
  - Otherwise load `pix_x`=`cnt_out` and move to EMIT.
- EMIT: `pix_valid`=1. `pix_x` and `pix_y` stay stable until `pix_valid` & `pix_ready`. On accept:
  - If `step_mode`==00, move to LINE (exactly one pixel per line).
  - Otherwise drive `cnt_enb`=1, `LoadVal`=`pix_x`, `Xmode`=`step_mode` in that same cycle and move to CAPT.
- LINE: `pix_y` increments. If the new `pix_y` == `y_lines`, move to DONE; otherwise move to SEED.
- DONE: `done`=1 for one cycle, then move to IDLE.
- `cnt_enb`=0, `Xmode`=00, `LoadVal`=0 in every cycle not listed above. The counter therefore clears between operations.
- `start` in any non-IDLE state is ignored.
- `x_start` > `x_end` gives an empty line (no pixels). Lines are still counted and `done` still fires.
- Arithmetic is performed by the counter only (W-bit, wraps modulo 2^W). The controller only compares values.

## Timing
- Reset values:
  - State = IDLE.
  - `cnt_enb`, `pix_valid`, `busy`, `done` = 0.
  - `Xmode` = 00; `LoadVal`, `pix_x`, `pix_y` = 0.
- Reset asserted mid-scan aborts immediately. No `done` pulse follows.
- `start` at cycle T:
  - SEED at T+1, CAPT at T+2.
  - First `pix_valid` at T+3.
- Sustained throughput with `pix_ready` held high: one pixel per 2 cycles (EMIT, CAPT).
- Last accept of the last line at cycle A: LINE at A+1 (A+2 if the last line ended through CAPT), DONE at A+2 (A+3).
- `pix_valid` never deasserts without an accept. `pix_ready` may toggle freely.
- Outputs are registered, except that `cnt_enb`, `Xmode` and `LoadVal` may be decoded from state and the accept condition.

## Configuration
- `PATTERN_SCAN_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge.
  - All outputs return to their reset values. No `done` pulse.
  - `abort` takes priority over a simultaneous accept.
- Not defined: the `abort` port is absent. A scan ends only at completion or on reset.

## Test plan
- Normal scan: `x_start`=10, `x_end`=20, `step_mode`=10, `y_lines`=2, `pix_ready`=1 → pixels (10,0), (14,0), (18,0), (10,1), (14,1), (18,1). Then a single `done` pulse and `busy` drops.
- Backpressure: same config with `pix_ready` low for 5 cycles on the second pixel → `pix_valid` held, `pix_x`=14 stable, no pixel lost or duplicated.
- Wrap: `x_start`=4090, `x_end`=4095, `step_mode`=11, `y_lines`=1 → exactly one pixel, (4090,0), then `done`.
- Zero-size cases:
  - `step_mode`=00, `y_lines`=3 → (x_start,0), (x_start,1), (x_start,2).
  - `y_lines`=0 → `done` at T+2, no `pix_valid`.
  - `x_start`=30, `x_end`=20 → no pixels, `done` still pulses.
- Reset mid-scan: `rst_n` pulled low while in EMIT → all outputs are 0 asynchronously. A new `start` after release scans from `pix_y`=0.
- `start` while busy is ignored. With `PATTERN_SCAN_ABORT_EN`, `abort` during line 1 → IDLE next cycle, no `done`.
